// File: rtl/heptane_lite_pkg.sv
// heptane_lite_pkg: opcodes, instruction fields, bundle geometry and bus bit positions.
package heptane_lite_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_SHL  = 4'd7,
    OP_BR   = 4'd8,
    OP_HALT = 4'd15
  } op_e;
  localparam int BUNDLE = 9;
  localparam int LINE_WORDS = 16;
  localparam int XLEN = 64;
  localparam int RW = 65;
  localparam int OP_LSB = 28;
  localparam int RT_LSB = 23;
  localparam int RA_LSB = 18;
  localparam int RB_LSB = 13;
  localparam int IMM_W = 13;
  localparam int BUS_VALID = 37;
  localparam int LINE_BITS = 32 * LINE_WORDS;
  localparam logic [3:0] REQ_TYPE = 4'h1;
  function automatic logic [3:0] f_op(input logic [31:0] w);
    return w[OP_LSB +: 4];
  endfunction
  function automatic logic [4:0] f_rt(input logic [31:0] w);
    return w[RT_LSB +: 5];
  endfunction
  function automatic logic [4:0] f_ra(input logic [31:0] w);
    return w[RA_LSB +: 5];
  endfunction
  function automatic logic [4:0] f_rb(input logic [31:0] w);
    return w[RB_LSB +: 5];
  endfunction
  function automatic logic [IMM_W-1:0] f_imm(input logic [31:0] w);
    return w[IMM_W-1:0];
  endfunction
endpackage

// File: rtl/heptane_lite_alu.sv
// heptane_lite_alu: one instruction's 65-bit result (bit 64 = carry/borrow) and write flag.
module heptane_lite_alu
  import heptane_lite_pkg::*;
(
  input  logic [3:0]       i_op,
  input  logic [RW-1:0]    i_a,
  input  logic [RW-1:0]    i_b,
  input  logic [IMM_W-1:0] i_imm,
  output logic [RW-1:0]    o_res,
  output logic             o_wr
);
  logic [XLEN-1:0] w_a, w_b, w_imm;
  logic w_unused;
  assign w_a = i_a[XLEN-1:0];
  assign w_b = i_b[XLEN-1:0];
  assign w_imm = {{(XLEN-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  assign w_unused = i_a[XLEN] ^ i_b[XLEN];
  always_comb begin
    o_wr = (i_op >= OP_ADD) && (i_op <= OP_SHL);
    case (i_op)
      OP_ADD:  o_res = {1'b0, w_a} + {1'b0, w_b};
      OP_SUB:  o_res = {1'b0, w_a} - {1'b0, w_b};
      OP_AND:  o_res = {1'b0, w_a & w_b};
      OP_OR:   o_res = {1'b0, w_a | w_b};
      OP_XOR:  o_res = {1'b0, w_a ^ w_b};
      OP_ADDI: o_res = {1'b0, w_a} + {1'b0, w_imm};
      OP_SHL:  o_res = {1'b0, w_a << w_b[5:0]};
      default: o_res = '0;
    endcase
  end
endmodule

// File: rtl/heptane_core_lite.sv
// heptane_core_lite: fetches 64-byte lines and executes up to 9 chained instructions per cycle,
// publishing a registered per-slot retire trace.
module heptane_core_lite
  import heptane_lite_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IRQ,
  input  logic                 IRQ_thr,
  input  logic [16:0]          IRQ_data,
  input  logic [67:0]          obusIn,
  output logic [81:0]          obusOut,
  output logic                 obusOut_want,
  input  logic                 obusOut_can,
  input  logic [37:0]          obusDIns,
  input  logic [567:0]         obusDIn_data,
  output logic [567:0]         obusDOut_dataAUD,
  output logic [75:0]          obusDOut_iosig,
  output logic                 obusDOut_want,
  input  logic                 obusDOut_can,
  input  logic                 obusDOut_replay,
  output logic                 retire_valid,
  output logic [9:0]           retire_xbreak,
  output logic [BUNDLE-1:0]    retire_en,
  output logic [BUNDLE*6-1:0]  retire_rT,
  output logic [BUNDLE*RW-1:0] retire_data
);
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;
  logic [1:0]               r_state;
  logic                     r_want;
  logic [XLEN-1:0]          r_pc;
  logic [3:0]               r_off;
  logic [31:0][RW-1:0]      r_regs;
  logic [LINE_BITS-1:0]     r_line;
  logic                     r_rv;
  logic [9:0]               r_xb;
  logic [BUNDLE-1:0]        r_en;
  logic [BUNDLE*6-1:0]      r_rt;
  logic [BUNDLE*RW-1:0]     r_data;
  logic [BUNDLE-1:0]        w_val, w_en, w_br, w_halt;
  logic [BUNDLE*6-1:0]      w_rt;
  logic [BUNDLE*RW-1:0]     w_res;
  logic [BUNDLE-1:0][XLEN-1:0] w_slot_tgt;
  logic [XLEN-1:0]          w_tgt;
  logic [3:0]               w_cnt;
  logic [4:0]               w_end;
  logic                     w_unused;
  genvar k;
  // Each slot sees the register file as left by the slots before it.
  for (k = 0; k < BUNDLE; k++) begin : g_s
    logic [31:0][RW-1:0] rf_i, rf_o;
    logic [4:0]          pos;
    logic [31:0]         word;
    logic [RW-1:0]       res;
    logic                stop_i, val, wr, brk;
    if (k == 0) begin : g_head
      assign rf_i = r_regs;
      assign stop_i = 1'b0;
    end else begin : g_tail
      assign rf_i = g_s[k-1].rf_o;
      assign stop_i = g_s[k-1].stop_i | g_s[k-1].brk;
    end
    assign pos = {1'b0, r_off} + 5'(k);
    assign val = !stop_i && !pos[4];
    assign word = r_line[{pos[3:0], 5'd0} +: 32];
    assign brk = val && (f_op(word) == OP_BR || f_op(word) == OP_HALT);
    heptane_lite_alu u_alu (
      .i_op  (f_op(word)),
      .i_a   (rf_i[f_ra(word)]),
      .i_b   (rf_i[f_rb(word)]),
      .i_imm (f_imm(word)),
      .o_res (res),
      .o_wr  (wr)
    );
    always_comb begin
      rf_o = rf_i;
      if (val && wr) rf_o[f_rt(word)] = res;
    end
    assign w_val[k] = val;
    assign w_en[k] = val && wr;
    assign w_br[k] = val && f_op(word) == OP_BR;
    assign w_halt[k] = val && f_op(word) == OP_HALT;
    assign w_rt[k*6 +: 6] = val ? {1'b0, f_rt(word)} : 6'd0;
    assign w_res[k*RW +: RW] = val ? res : '0;
    assign w_slot_tgt[k] = {r_pc[XLEN-1:6], pos[3:0], 2'd0}
                         + {{(XLEN-IMM_W-2){word[IMM_W-1]}}, f_imm(word), 2'd0};
  end
  always_comb begin
    w_tgt = '0;
    w_cnt = '0;
    for (int i = 0; i < BUNDLE; i++) begin
      w_tgt = w_br[i] ? w_slot_tgt[i] : w_tgt;
      w_cnt = w_cnt + 4'(w_val[i]);
    end
    w_end = {1'b0, r_off} + {1'b0, w_cnt};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
      r_want  <= 1'b0;
      r_pc    <= '0;
      r_off   <= '0;
      r_regs  <= '0;
      r_line  <= '0;
      r_rv    <= 1'b0;
      r_xb    <= '1;
      r_en    <= '0;
      r_rt    <= '0;
      r_data  <= '0;
    end else begin
      r_rv   <= 1'b0;
      r_xb   <= '1;
      r_en   <= '0;
      r_rt   <= '0;
      r_data <= '0;
      case (r_state)
        S_REQ: begin
          r_want <= !(r_want && obusOut_can);
          if (r_want && obusOut_can) r_state <= S_WAIT;
        end
        S_WAIT: if (obusDIns[BUS_VALID]) begin
          r_line  <= obusDIn_data[LINE_BITS-1:0];
          r_off   <= r_pc[5:2];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_regs <= g_s[BUNDLE-1].rf_o;
          r_rv   <= 1'b1;
          r_xb   <= {1'b1, ~w_val};
          r_en   <= w_en;
          r_rt   <= w_rt;
          r_data <= w_res;
          if (|w_halt) r_state <= S_HALT;
          else if (|w_br) begin
            r_pc    <= w_tgt;
            r_state <= S_REQ;
          end else if (w_end[4]) begin
            r_pc    <= {r_pc[XLEN-1:6] + 58'd1, 6'd0};
            r_state <= S_REQ;
          end else r_off <= w_end[3:0];
        end
        default: ;
      endcase
    end
  end
  assign obusOut = r_want ? {REQ_TYPE, 14'd0, r_pc[XLEN-1:6], 6'd0} : '0;
  assign obusOut_want = r_want;
  assign obusDOut_dataAUD = '0;
  assign obusDOut_iosig = '0;
  assign obusDOut_want = 1'b0;
  assign retire_valid = r_rv;
  assign retire_xbreak = r_xb;
  assign retire_en = r_en;
  assign retire_rT = r_rt;
  assign retire_data = r_data;
  assign w_unused = ^{IRQ, IRQ_thr, IRQ_data, obusIn, obusDIns[BUS_VALID-1:0],
                      obusDIn_data[567:LINE_BITS], obusDOut_can, obusDOut_replay, r_pc[1:0]};
endmodule

// File: tb/tb_heptane_core_lite.sv
// tb_heptane_core_lite: directed scenarios with hand-computed retire traces and bus addresses.
module tb_heptane_core_lite;
  import heptane_lite_pkg::*;
  logic clk = 0, rst = 1;
  logic IRQ = 0, IRQ_thr = 0;
  logic [16:0] IRQ_data = '0;
  logic [67:0] obusIn = '0;
  logic [81:0] obusOut;
  logic obusOut_want, obusOut_can = 0;
  logic [37:0] obusDIns = '0;
  logic [567:0] obusDIn_data = '0;
  logic [567:0] obusDOut_dataAUD;
  logic [75:0] obusDOut_iosig;
  logic obusDOut_want, obusDOut_can = 0, obusDOut_replay = 0;
  logic retire_valid;
  logic [9:0] retire_xbreak;
  logic [8:0] retire_en;
  logic [53:0] retire_rT;
  logic [584:0] retire_data;
  int errors = 0, checks = 0;
  logic [31:0] mem [0:31];

  heptane_core_lite dut (
    .clk(clk), .rst(rst), .IRQ(IRQ), .IRQ_thr(IRQ_thr), .IRQ_data(IRQ_data), .obusIn(obusIn),
    .obusOut(obusOut), .obusOut_want(obusOut_want), .obusOut_can(obusOut_can),
    .obusDIns(obusDIns), .obusDIn_data(obusDIn_data), .obusDOut_dataAUD(obusDOut_dataAUD),
    .obusDOut_iosig(obusDOut_iosig), .obusDOut_want(obusDOut_want), .obusDOut_can(obusDOut_can),
    .obusDOut_replay(obusDOut_replay), .retire_valid(retire_valid), .retire_xbreak(retire_xbreak),
    .retire_en(retire_en), .retire_rT(retire_rT), .retire_data(retire_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [4:0] rt, input logic [4:0] ra,
                                      input logic [4:0] rb, input logic [12:0] imm);
    return {op, rt, ra, rb, imm};
  endfunction

  task automatic clear_mem;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset;
    rst = 1; obusOut_can = 0; obusDIns = '0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic serve(output logic [63:0] addr, output logic ok);
    ok = 0; addr = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (obusOut_want) begin ok = 1; break; end
    end
    if (ok) begin
      addr = obusOut[63:0];
      obusOut_can = 1;
      @(negedge clk);
      obusOut_can = 0;
      for (int i = 0; i < 16; i++) obusDIn_data[32*i +: 32] = mem[{addr[6], 4'(i)}];
      obusDIns = {1'b1, 37'd0};
      @(negedge clk);
      obusDIns = '0;
    end
  endtask

  task automatic next_retire(output logic ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (retire_valid) begin ok = 1; break; end
    end
  endtask

  task automatic quiet(output int n);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (retire_valid || obusOut_want) n++;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (retire_valid !== 1'b0 || retire_xbreak !== 10'h3FF || retire_en !== 9'h0) begin
      errors++; $display("FAIL reset_retire: got v=%b xb=%h en=%h, want v=0 xb=3ff en=0", retire_valid, retire_xbreak, retire_en); end
    checks++; if (obusOut_want !== 1'b0 || obusOut !== '0 || obusDOut_want !== 1'b0 || obusDOut_dataAUD !== '0 || obusDOut_iosig !== '0) begin
      errors++; $display("FAIL reset_bus: got want=%b out=%h dwant=%b, want all 0", obusOut_want, obusOut, obusDOut_want); end
    checks++; if (retire_data !== '0 || retire_rT !== '0) begin
      errors++; $display("FAIL reset_data: got rT=%h data nonzero=%b, want 0", retire_rT, |retire_data); end
    rst = 0;
    @(negedge clk);
    checks++; if (obusOut_want !== 1'b1 || obusOut !== {4'h1, 14'd0, 64'd0}) begin
      errors++; $display("FAIL reset_first_req: got want=%b out=%h, want 1 and %h", obusOut_want, obusOut, {4'h1, 14'd0, 64'd0}); end
  endtask

  task automatic test_basic;
    logic [63:0] a; logic ok; int n;
    clear_mem;
    mem[0] = ins(OP_ADDI, 1, 0, 0, 13'd5);
    mem[1] = ins(OP_ADDI, 2, 1, 0, 13'd7);
    mem[2] = ins(OP_ADD, 3, 1, 2, 13'd0);
    mem[3] = ins(OP_HALT, 0, 0, 0, 13'd0);
    do_reset;
    serve(a, ok);
    checks++; if (!ok || a !== 64'h0) begin errors++; $display("FAIL basic_addr: got ok=%b addr=%h, want 1 and 0", ok, a); end
    next_retire(ok);
    checks++; if (!ok || retire_xbreak !== 10'h3F0 || retire_en !== 9'h007) begin
      errors++; $display("FAIL basic_shape: got ok=%b xb=%h en=%h, want 1 3f0 007", ok, retire_xbreak, retire_en); end
    checks++; if (retire_data[0 +: 65] !== 65'd5 || retire_data[65 +: 65] !== 65'd12 || retire_data[130 +: 65] !== 65'd17) begin
      errors++; $display("FAIL basic_data: got %h %h %h, want 5 c 11", retire_data[0 +: 65], retire_data[65 +: 65], retire_data[130 +: 65]); end
    checks++; if (retire_rT[12 +: 6] !== 6'd3 || retire_rT[6 +: 6] !== 6'd2) begin
      errors++; $display("FAIL basic_rt: got slot1=%0d slot2=%0d, want 2 3", retire_rT[6 +: 6], retire_rT[12 +: 6]); end
    quiet(n);
    checks++; if (n !== 0) begin errors++; $display("FAIL basic_halted: got %0d active cycles, want 0", n); end
  endtask

  task automatic test_wide;
    logic [63:0] a; logic ok; int n;
    clear_mem;
    for (int i = 0; i < 16; i++) mem[i] = ins(OP_ADDI, 1, 1, 0, 13'd1);
    mem[16] = ins(OP_HALT, 0, 0, 0, 13'd0);
    do_reset;
    serve(a, ok);
    next_retire(ok);
    checks++; if (!ok || retire_xbreak !== 10'h200 || retire_en !== 9'h1FF || retire_data[520 +: 65] !== 65'd9) begin
      errors++; $display("FAIL wide_b1: got ok=%b xb=%h en=%h d8=%h, want 1 200 1ff 9", ok, retire_xbreak, retire_en, retire_data[520 +: 65]); end
    next_retire(ok);
    checks++; if (!ok || retire_xbreak !== 10'h380 || retire_en !== 9'h07F || retire_data[390 +: 65] !== 65'd16) begin
      errors++; $display("FAIL wide_b2: got ok=%b xb=%h en=%h d6=%h, want 1 380 07f 10", ok, retire_xbreak, retire_en, retire_data[390 +: 65]); end
    serve(a, ok);
    checks++; if (!ok || a !== 64'h40) begin errors++; $display("FAIL wide_refetch: got ok=%b addr=%h, want 1 40", ok, a); end
    next_retire(ok);
    checks++; if (!ok || retire_xbreak !== 10'h3FE || retire_en !== 9'h0) begin
      errors++; $display("FAIL wide_halt: got ok=%b xb=%h en=%h, want 1 3fe 0", ok, retire_xbreak, retire_en); end
    quiet(n);
    checks++; if (n !== 0) begin errors++; $display("FAIL wide_halted: got %0d active cycles, want 0", n); end
  endtask

  task automatic test_carry;
    logic [63:0] a; logic ok;
    clear_mem;
    mem[0] = ins(OP_ADDI, 1, 0, 0, 13'h1FFF);
    mem[1] = ins(OP_ADD, 2, 1, 1, 13'd0);
    mem[2] = ins(OP_HALT, 0, 0, 0, 13'd0);
    do_reset;
    serve(a, ok);
    next_retire(ok);
    checks++; if (!ok || retire_data[0 +: 65] !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      errors++; $display("FAIL carry_addi: got ok=%b d0=%h, want 0ffffffffffffffff", ok, retire_data[0 +: 65]); end
    checks++; if (retire_data[65 +: 65] !== 65'h1_FFFF_FFFF_FFFF_FFFE || retire_en !== 9'h003) begin
      errors++; $display("FAIL carry_add: got d1=%h en=%h, want 1fffffffffffffffe 003", retire_data[65 +: 65], retire_en); end
  endtask

  task automatic test_ops;
    logic [63:0] a; logic ok;
    clear_mem;
    mem[0] = ins(OP_ADDI, 1, 0, 0, 13'd3);
    mem[1] = ins(OP_ADDI, 2, 0, 0, 13'd5);
    mem[2] = ins(OP_SUB, 3, 1, 2, 13'd0);
    mem[3] = ins(OP_AND, 4, 1, 2, 13'd0);
    mem[4] = ins(OP_OR, 5, 1, 2, 13'd0);
    mem[5] = ins(OP_XOR, 6, 1, 2, 13'd0);
    mem[6] = ins(OP_SHL, 7, 1, 2, 13'd0);
    mem[7] = ins(OP_ADDI, 1, 0, 0, 13'd9);
    mem[8] = ins(4'd9, 8, 1, 1, 13'd0);
    mem[9] = ins(OP_ADD, 8, 1, 0, 13'd0);
    mem[10] = ins(OP_HALT, 0, 0, 0, 13'd0);
    do_reset;
    serve(a, ok);
    next_retire(ok);
    checks++; if (!ok || retire_xbreak !== 10'h200 || retire_en !== 9'h0FF) begin
      errors++; $display("FAIL ops_shape: got ok=%b xb=%h en=%h, want 1 200 0ff", ok, retire_xbreak, retire_en); end
    checks++; if (retire_data[130 +: 65] !== 65'h1_FFFF_FFFF_FFFF_FFFE || retire_data[195 +: 65] !== 65'd1 || retire_data[260 +: 65] !== 65'd7) begin
      errors++; $display("FAIL ops_sub_and_or: got %h %h %h, want 1fffffffffffffffe 1 7", retire_data[130 +: 65], retire_data[195 +: 65], retire_data[260 +: 65]); end
    checks++; if (retire_data[325 +: 65] !== 65'd6 || retire_data[390 +: 65] !== 65'h60) begin
      errors++; $display("FAIL ops_xor_shl: got %h %h, want 6 60", retire_data[325 +: 65], retire_data[390 +: 65]); end
    next_retire(ok);
    checks++; if (!ok || retire_xbreak !== 10'h3FC || retire_en !== 9'h001 || retire_data[0 +: 65] !== 65'd9) begin
      errors++; $display("FAIL ops_last_wins: got ok=%b xb=%h en=%h d0=%h, want 1 3fc 001 9", ok, retire_xbreak, retire_en, retire_data[0 +: 65]); end
  endtask

  task automatic test_branch;
    logic [63:0] a; logic ok;
    clear_mem;
    mem[0] = ins(OP_BR, 0, 0, 0, 13'd8);
    mem[1] = ins(OP_ADDI, 9, 0, 0, 13'd1);
    mem[8] = ins(OP_ADDI, 4, 0, 0, 13'd3);
    mem[9] = ins(OP_ADDI, 5, 0, 0, 13'd4);
    mem[10] = ins(OP_BR, 0, 0, 0, 13'd16);
    mem[11] = ins(OP_ADDI, 6, 0, 0, 13'd9);
    for (int i = 16; i < 26; i++) mem[i] = ins(OP_ADDI, 7, 0, 0, 13'd99);
    mem[26] = ins(OP_ADD, 7, 4, 5, 13'd0);
    mem[27] = ins(OP_HALT, 0, 0, 0, 13'd0);
    do_reset;
    serve(a, ok);
    next_retire(ok);
    checks++; if (!ok || retire_xbreak !== 10'h3FE || retire_en !== 9'h0) begin
      errors++; $display("FAIL br_first: got ok=%b xb=%h en=%h, want 1 3fe 0", ok, retire_xbreak, retire_en); end
    serve(a, ok);
    checks++; if (!ok || a !== 64'h0) begin errors++; $display("FAIL br_addr0: got ok=%b addr=%h, want 1 0", ok, a); end
    next_retire(ok);
    checks++; if (!ok || retire_xbreak !== 10'h3F8 || retire_en !== 9'h003 || retire_data[65 +: 65] !== 65'd4) begin
      errors++; $display("FAIL br_trunc: got ok=%b xb=%h en=%h d1=%h, want 1 3f8 003 4", ok, retire_xbreak, retire_en, retire_data[65 +: 65]); end
    serve(a, ok);
    checks++; if (!ok || a !== 64'h40) begin errors++; $display("FAIL br_addr40: got ok=%b addr=%h, want 1 40", ok, a); end
    next_retire(ok);
    checks++; if (!ok || retire_xbreak !== 10'h3FC || retire_en !== 9'h001 || retire_data[0 +: 65] !== 65'd7 || retire_rT[0 +: 6] !== 6'd7) begin
      errors++; $display("FAIL br_resume: got ok=%b xb=%h en=%h d0=%h rt=%0d, want 1 3fc 001 7 7", ok, retire_xbreak, retire_en, retire_data[0 +: 65], retire_rT[0 +: 6]); end
  endtask

  task automatic test_stall_reset;
    logic [63:0] a; logic ok; logic [81:0] held; int bad;
    clear_mem;
    for (int i = 0; i < 16; i++) mem[i] = ins(OP_ADDI, 1, 1, 0, 13'd1);
    do_reset;
    @(negedge clk);
    held = obusOut;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      obusDIns = (i >= 10 && i < 13) ? {1'b1, 37'd0} : '0;
      @(negedge clk);
      if (obusOut_want !== 1'b1 || obusOut !== held || retire_valid !== 1'b0) bad++;
    end
    obusDIns = '0;
    checks++; if (bad !== 0 || held !== {4'h1, 14'd0, 64'd0}) begin
      errors++; $display("FAIL stall_hold: got %0d bad cycles held=%h, want 0 and %h", bad, held, {4'h1, 14'd0, 64'd0}); end
    serve(a, ok);
    checks++; if (!ok || a !== 64'h0) begin errors++; $display("FAIL stall_addr: got ok=%b addr=%h, want 1 0", ok, a); end
    rst = 1;
    @(negedge clk);
    checks++; if (retire_valid !== 1'b0 || retire_xbreak !== 10'h3FF || retire_en !== 9'h0 || retire_data !== '0 || obusOut_want !== 1'b0) begin
      errors++; $display("FAIL stall_abort: got v=%b xb=%h en=%h want=%b, want 0 3ff 0 0", retire_valid, retire_xbreak, retire_en, obusOut_want); end
    rst = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wide;
    test_carry;
    test_ops;
    test_branch;
    test_stall_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
